// File: rtl/bldc_main.sv
// Six-step trapezoidal BLDC commutation controller: Hall decode, PWM chopping of the
// active high side, dead time on every commutation change, all-off on invalid Hall codes.
module bldc_main #(
  parameter int PWM_BITS    = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                H1,
  input  logic                H2,
  input  logic                H3,
  input  logic [PWM_BITS-1:0] D,
  output logic                A_OUT,
  output logic                AA_OUT,
  output logic                B_OUT,
  output logic                BB_OUT,
  output logic                C_OUT,
  output logic                CC_OUT
);

  localparam int DW = (DEAD_CYCLES < 1) ? 1 : $clog2(DEAD_CYCLES + 1);

  typedef struct packed {
    logic a_hi;
    logic a_lo;
    logic b_hi;
    logic b_lo;
    logic c_hi;
    logic c_lo;
  } gates_t;

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  hs;
  logic [2:0]                  hs_prev_q;
  logic [DW-1:0]               dead_q, dead_d;
  logic [PWM_BITS-1:0]         cnt_q, cnt_d;
  logic [PWM_BITS-1:0]         duty_q, duty_d;
  logic                        pwm;
  logic [2:0]                  hi_sel, lo_sel;   // {A,B,C} phase selects from the Hall table
  gates_t                      gates_q, gates_d;

  assign hs = sync_q[SYNC_STAGES-1];

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    dead_d  = dead_q;
    cnt_d   = cnt_q + 1'b1;
    duty_d  = duty_q;
    hi_sel  = 3'b000;
    lo_sel  = 3'b000;
    gates_d = '0;

    if (hs != hs_prev_q) begin
      dead_d = DW'(DEAD_CYCLES);
    end else if (dead_q != '0) begin
      dead_d = dead_q - 1'b1;
    end

    // Duty only changes at the period boundary so a period is never cut short or stretched.
    if (cnt_q == '1) begin
      duty_d = D;
    end
    pwm = (cnt_q < duty_q);

    case (hs)
      3'b100:  begin hi_sel = 3'b100; lo_sel = 3'b010; end
      3'b101:  begin hi_sel = 3'b100; lo_sel = 3'b001; end
      3'b001:  begin hi_sel = 3'b010; lo_sel = 3'b001; end
      3'b011:  begin hi_sel = 3'b010; lo_sel = 3'b100; end
      3'b010:  begin hi_sel = 3'b001; lo_sel = 3'b100; end
      3'b110:  begin hi_sel = 3'b001; lo_sel = 3'b010; end
      default: begin hi_sel = 3'b000; lo_sel = 3'b000; end
    endcase

    // Blanking on the next-state dead count makes the change cycle itself count as dead.
    if (dead_d == '0) begin
      gates_d.a_hi = hi_sel[2] & pwm;
      gates_d.b_hi = hi_sel[1] & pwm;
      gates_d.c_hi = hi_sel[0] & pwm;
      gates_d.a_lo = lo_sel[2];
      gates_d.b_lo = lo_sel[1];
      gates_d.c_lo = lo_sel[0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      hs_prev_q <= 3'b000;
      dead_q    <= '0;
      cnt_q     <= '0;
      duty_q    <= '0;
      gates_q   <= '0;
    end else begin
      sync_q[0] <= {H1, H2, H3};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hs_prev_q <= hs;
      dead_q    <= dead_d;
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      gates_q   <= gates_d;
    end
  end

  assign A_OUT  = gates_q.a_hi;
  assign AA_OUT = gates_q.a_lo;
  assign B_OUT  = gates_q.b_hi;
  assign BB_OUT = gates_q.b_lo;
  assign C_OUT  = gates_q.c_hi;
  assign CC_OUT = gates_q.c_lo;

endmodule

// File: tb/tb_bldc_main.sv
// Directed bench for bldc_main: reset, commutation table, latency/dead time, faults,
// duty boundaries and asynchronous reset, with a shoot-through check on every sample.
module tb_bldc_main;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       H1 = 1'b0, H2 = 1'b0, H3 = 1'b0;
  logic [3:0] D = 4'd0;
  logic       A_OUT, AA_OUT, B_OUT, BB_OUT, C_OUT, CC_OUT;

  bldc_main #(.PWM_BITS(4), .DEAD_CYCLES(2), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .H1     (H1),
    .H2     (H2),
    .H3     (H3),
    .D      (D),
    .A_OUT  (A_OUT),
    .AA_OUT (AA_OUT),
    .B_OUT  (B_OUT),
    .BB_OUT (BB_OUT),
    .C_OUT  (C_OUT),
    .CC_OUT (CC_OUT)
  );

  always #10 clk = ~clk;

  // Output vector order {A, AA, B, BB, C, CC}
  wire [5:0] outv = {A_OUT, AA_OUT, B_OUT, BB_OUT, C_OUT, CC_OUT};

  localparam logic [5:0] HI_A = 6'b100000, LO_A = 6'b010000;
  localparam logic [5:0] HI_B = 6'b001000, LO_B = 6'b000100;
  localparam logic [5:0] HI_C = 6'b000010, LO_C = 6'b000001;

  typedef struct {
    logic [2:0] hall;
    logic [5:0] hi;
    logic [5:0] lo;
  } vec_t;

  vec_t       seq [6];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc;
  int         on_cnt, bad;
  logic       found;
  logic [5:0] prev_hi, prev_lo;

  // Edges since reset release; after each edge the PWM counter equals cyc mod 16.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      check("shoot_through",
            32'((outv[5] & outv[4]) | (outv[3] & outv[2]) | (outv[1] & outv[0])), 32'd0);
    end
  endtask

  task automatic set_hall(input logic [2:0] h);
    {H1, H2, H3} = h;
  endtask

  // Over 16 consecutive samples: count high-side on-cycles, and count samples where
  // anything besides the chopped high side differs from the expected low-side pattern.
  task automatic window(input logic [5:0] hi, input logic [5:0] lo,
                        output int on_n, output int bad_n);
    on_n  = 0;
    bad_n = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if ((outv & hi) != 6'b0) on_n++;
      if ((outv & ~hi) !== lo) bad_n++;
    end
  endtask

  initial begin
    seq[0] = '{3'b101, HI_A, LO_C};
    seq[1] = '{3'b001, HI_B, LO_C};
    seq[2] = '{3'b011, HI_B, LO_A};
    seq[3] = '{3'b010, HI_C, LO_A};
    seq[4] = '{3'b110, HI_C, LO_B};
    seq[5] = '{3'b100, HI_A, LO_B};

    // Reset with H=100, D=11
    set_hall(3'b100);
    D = 4'd11;
    #1 rst = 1'b1;
    step(5);
    check("reset_outputs", outv, 6'b0);
    rst = 1'b0;

    step(4);
    check("release_dead", outv, 6'b0);
    step(1);
    check("release_first_pattern", outv, 6'b000100);
    step(11);
    check("duty0_until_wrap", outv, 6'b000100);
    step(1);
    check("duty11_first_on", outv, 6'b100100);
    window(HI_A, LO_B, on_cnt, bad);
    check("release_duty_11", on_cnt, 11);
    check("release_pattern", bad, 0);

    // Forward Hall sequence, 50 clk per step
    prev_hi = HI_A;
    prev_lo = LO_B;
    for (int s = 0; s < 6; s++) begin
      set_hall(seq[s].hall);
      step(2);
      check($sformatf("seq%0d_old_pattern", s), outv & ~prev_hi, prev_lo);
      step(1);
      check($sformatf("seq%0d_dead1", s), outv, 6'b0);
      step(1);
      check($sformatf("seq%0d_dead2", s), outv, 6'b0);
      step(1);
      check($sformatf("seq%0d_new_pattern", s), outv & ~seq[s].hi, seq[s].lo);
      window(seq[s].hi, seq[s].lo, on_cnt, bad);
      check($sformatf("seq%0d_duty", s), on_cnt, 11);
      check($sformatf("seq%0d_pattern", s), bad, 0);
      step(29);
      prev_hi = seq[s].hi;
      prev_lo = seq[s].lo;
    end

    // Invalid Hall codes 000 then 111, then back to 100
    set_hall(3'b000);
    step(2);
    check("fault_old_pattern", outv & ~HI_A, LO_B);
    step(1);
    check("fault000_first", outv, 6'b0);
    bad = 0;
    for (int i = 0; i < 47; i++) begin
      step(1);
      if (outv !== 6'b0) bad++;
    end
    check("fault000_hold", bad, 0);
    set_hall(3'b111);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (outv !== 6'b0) bad++;
    end
    check("fault111_hold", bad, 0);
    set_hall(3'b100);
    step(4);
    check("recover_dead", outv, 6'b0);
    step(1);
    check("recover_pattern", outv & ~HI_A, LO_B);
    window(HI_A, LO_B, on_cnt, bad);
    check("recover_duty", on_cnt, 11);
    check("recover_pattern_window", bad, 0);

    // Duty extremes
    D = 4'd0;
    step(40);
    window(HI_A, LO_B, on_cnt, bad);
    check("duty0_on", on_cnt, 0);
    check("duty0_low_side", bad, 0);
    D = 4'd15;
    step(40);
    window(HI_A, LO_B, on_cnt, bad);
    check("duty15_on", on_cnt, 15);
    check("duty15_low_side", bad, 0);

    // Duty change mid-period (at cnt==5): 15 stays active until the wrap, then 3
    for (int i = 0; i < 16 && (cyc % 16) != 5; i++) step(1);
    check("align_cnt5", cyc % 16, 5);
    D = 4'd3;
    step(10);
    check("mid_old_duty_cnt14", outv, 6'b100100);
    step(1);
    check("mid_cnt15_off", outv, 6'b000100);
    step(3);
    check("new_duty_cnt2_on", outv, 6'b100100);
    step(1);
    check("new_duty_cnt3_off", outv, 6'b000100);

    // Asynchronous reset while A_OUT is high
    found = 1'b0;
    for (int i = 0; i < 32 && !found; i++) begin
      step(1);
      found = outv[5];
    end
    check("a_high_seen", found, 1'b1);
    #3 rst = 1'b1;
    #1 check("async_reset", outv, 6'b0);
    step(3);
    check("reset_hold", outv, 6'b0);
    rst = 1'b0;
    step(4);
    check("rerelease_dead", outv, 6'b0);
    step(1);
    check("rerelease_pattern", outv, 6'b000100);
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
